// File: rtl/rx_sequencer.sv
// rx_sequencer -- receive control unit of the UART receiver.
//
// Watches the raw serial line for a start bit, times every bit period and
// pulses shift_strobe near the middle of each of the nine bits that follow
// the start bit (8 data bits, LSB first, then the stop bit). The bits are
// collected by an external sr_9bit shift register. After the ninth strobe
// the stop bit is checked. A good frame is copied into the rx_data buffer.
//
// Ports
//   clk            system clock, all flops on the rising edge
//   n_rst          asynchronous active-low reset
//   serial_in      raw serial line, idle high, asynchronous to clk
//   stop_bit       stop-bit output of sr_9bit
//   packet_data    data-bit outputs of sr_9bit
//   data_read      one-cycle pulse: the consumer has taken rx_data
//   shift_strobe   one-cycle shift enable to sr_9bit
//   rx_data        buffered received byte (8'hFF after reset)
//   data_ready     rx_data holds an unread byte
//   overrun_error  a byte was overwritten before it was read
//   framing_error  the last frame had a stop bit of 0
//   busy           the sequencer is inside a frame (state != IDLE)
//
// Consumer handshake: data_ready acts as "valid" and data_read as a one-cycle
// "taken" pulse. A pulse while data_ready is high clears data_ready and
// overrun_error on the next cycle. A pulse in the cycle that loads a new byte
// only clears overrun_error, because the new byte is still unread.
module rx_sequencer #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       serial_in,
   input  logic       stop_bit,
   input  logic [7:0] packet_data,
   input  logic       data_read,
   output logic       shift_strobe,
   output logic [7:0] rx_data,
   output logic       data_ready,
   output logic       overrun_error,
   output logic       framing_error,
   output logic       busy
);

   // Timer width: ceil(log2(1.5 * CLKS_PER_BIT)), computed in integers.
   localparam int TW = $clog2((3 * CLKS_PER_BIT + 1) / 2);

   localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] START    = 3'd1;
   localparam logic [2:0] RECEIVE  = 3'd2;
   localparam logic [2:0] STOP_CHK = 3'd3;
   localparam logic [2:0] LOAD     = 3'd4;

   logic [2:0]    state;
   logic [TW-1:0] timer;
   logic [3:0]    bit_cnt;
   logic          s1, s2, s3;
   logic          start_edge;

   // s1/s2 resynchronise the line. s3 is s2 delayed by one cycle, so a
   // high-to-low step of the synchronised line marks the start bit.
   assign start_edge = s3 & ~s2;

   assign shift_strobe = (state == RECEIVE) && (timer == '0);
   assign busy         = (state != IDLE);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state         <= IDLE;
         timer         <= '0;
         bit_cnt       <= '0;
         s1            <= 1'b1;
         s2            <= 1'b1;
         s3            <= 1'b1;
         rx_data       <= 8'hFF;
         data_ready    <= 1'b0;
         overrun_error <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         s1 <= serial_in;
         s2 <= s1;
         s3 <= s2;

         // Outside LOAD a read simply empties the buffer. LOAD handles the
         // coincident case itself.
         if (data_read && (state != LOAD)) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start_edge) begin
                  state         <= START;
                  timer         <= HALF_LOAD;
                  framing_error <= 1'b0;
               end
            end

            START: begin
               // Half a bit after the edge: a line that is high again was a
               // glitch, not a start bit.
               if (timer == '0) begin
                  if (s2) begin
                     state <= IDLE;
                  end else begin
                     state   <= RECEIVE;
                     timer   <= FULL_LOAD;
                     bit_cnt <= '0;
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end

            RECEIVE: begin
               if (timer == '0) begin
                  timer   <= FULL_LOAD;
                  bit_cnt <= bit_cnt + 4'd1;
                  // bit_cnt == 8 here means this strobe is the ninth one.
                  if (bit_cnt == 4'd8) begin
                     state <= STOP_CHK;
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end

            STOP_CHK: begin
               if (stop_bit) begin
                  state <= LOAD;
               end else begin
                  framing_error <= 1'b1;
                  state         <= IDLE;
               end
            end

            LOAD: begin
               rx_data    <= packet_data;
               data_ready <= 1'b1;
               if (data_read) begin
                  overrun_error <= 1'b0;
               end else if (data_ready) begin
                  overrun_error <= 1'b1;
               end
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_sequencer.sv
// Testbench for rx_sequencer (CLKS_PER_BIT = 10).
// Contains a model of the external sr_9bit register, a frame-level reference
// model, a per-cycle compare process, directed scenarios and a random phase.
module tb_rx_sequencer;

   localparam int N         = 10;
   localparam int H         = N / 2;
   // Ages are counted in cycles after the cycle in which the start edge is
   // seen. START covers ages 1..H. The j-th strobe falls at age H + j*N.
   localparam int LAST_STB  = H + 9 * N;
   localparam int STOP_AGE  = LAST_STB + 1;
   localparam int LOAD_AGE  = LAST_STB + 2;

   // ---------------- clock / reset / signals ----------------
   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       serial_in = 1'b1;
   logic       data_read = 1'b0;
   logic       stop_bit;
   logic [7:0] packet_data;
   logic       shift_strobe;
   logic [7:0] rx_data;
   logic       data_ready;
   logic       overrun_error;
   logic       framing_error;
   logic       busy;

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   logic check_en = 1'b0;

   always @(posedge clk) cycle <= cycle + 1;

   rx_sequencer #(.CLKS_PER_BIT(N)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .serial_in    (serial_in),
      .stop_bit     (stop_bit),
      .packet_data  (packet_data),
      .data_read    (data_read),
      .shift_strobe (shift_strobe),
      .rx_data      (rx_data),
      .data_ready   (data_ready),
      .overrun_error(overrun_error),
      .framing_error(framing_error),
      .busy         (busy)
   );

   // ---------------- sr_9bit stand-in ----------------
   // Shifts the line in at every strobe, LSB first, so after nine strobes
   // bit 8 is the stop bit and bits 7:0 are the data byte.
   logic [8:0] sr;
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) sr <= '0;
      else if (shift_strobe) sr <= {serial_in, sr[8:1]};
   end
   assign stop_bit    = sr[8];
   assign packet_data = sr[7:0];

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Frames sent by the driver, {stop, data}, in line order.
   logic [8:0] exp_q[$];

   // ---------------- reference model ----------------
   int         m_age;      // -1 = idle, otherwise age of the current cycle
   logic [2:0] m_line;     // line history: [1] two cycles old, [2] three
   logic [7:0] m_rx;
   logic [7:0] m_pend;
   logic       m_ready;
   logic       m_ovr;
   logic       m_fe;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_age   <= -1;
         m_line  <= 3'b111;
         m_rx    <= 8'hFF;
         m_pend  <= 8'h00;
         m_ready <= 1'b0;
         m_ovr   <= 1'b0;
         m_fe    <= 1'b0;
      end else begin
         m_line <= {m_line[1:0], serial_in};
         if (data_read && (m_age != LOAD_AGE)) begin
            m_ready <= 1'b0;
            m_ovr   <= 1'b0;
         end
         if (m_age < 0) begin
            if (m_line[2] && !m_line[1]) begin
               m_age <= 1;
               m_fe  <= 1'b0;
            end
         end else if ((m_age == H) && m_line[1]) begin
            m_age <= -1;
         end else if (m_age == STOP_AGE) begin
            if (exp_q.size() == 0) begin
               check("frame_queue_nonempty", 32'd0, 32'd1);
               m_age <= -1;
            end else begin
               if (exp_q[0][8]) begin
                  m_pend <= exp_q[0][7:0];
                  m_age  <= m_age + 1;
               end else begin
                  m_fe  <= 1'b1;
                  m_age <= -1;
               end
               void'(exp_q.pop_front());
            end
         end else if (m_age == LOAD_AGE) begin
            m_rx    <= m_pend;
            m_ready <= 1'b1;
            if (data_read) m_ovr <= 1'b0;
            else if (m_ready) m_ovr <= 1'b1;
            m_age <= -1;
         end else begin
            m_age <= m_age + 1;
         end
      end
   end

   // Per-cycle comparison, on the falling edge.
   always @(negedge clk) begin
      if (check_en) begin
         check("shift_strobe", shift_strobe,
               (m_age > H) && (((m_age - H) % N) == 0) && (m_age <= LAST_STB));
         check("busy", busy, m_age >= 0);
         check("rx_data", rx_data, m_rx);
         check("data_ready", data_ready, m_ready);
         check("overrun_error", overrun_error, m_ovr);
         check("framing_error", framing_error, m_fe);
      end
   end

   // Strobe timestamps, used for spacing checks.
   int stb_q[$];
   always @(negedge clk) if (shift_strobe === 1'b1) stb_q.push_back(cycle);

   // ---------------- driver tasks ----------------
   // Hold line/read for one cycle; returns 1 time unit after the next edge.
   task automatic step(input logic line, input logic rd);
      serial_in = line;
      data_read = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input int rmode);
      for (int i = 0; i < n; i++) step(1'b1, (rmode == 1) && ($urandom_range(0, 49) == 0));
   endtask

   // rmode: 0 no reads, 1 sparse random reads, 2 read pulse in the LOAD cycle.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int rmode,
                             input logic chk_fe);
      logic [9:0] bits;
      logic       rd;
      bits = {stop, d, 1'b0};
      exp_q.push_back({stop, d});
      for (int k = 0; k < 10 * N; k++) begin
         if (rmode == 1) rd = ($urandom_range(0, 99) == 0);
         else rd = (rmode == 2) && (k == 10 * N - 1);
         step(bits[k / N], rd);
         if (chk_fe && (k == N)) check("fe_cleared_by_start", framing_error, 1'b0);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #3 n_rst = 1'b1;
      @(posedge clk);
      #1;
      check_en = 1'b1;

      // Reset state
      check("rst_rx_data", rx_data, 8'hFF);
      check("rst_data_ready", data_ready, 1'b0);
      check("rst_overrun", overrun_error, 1'b0);
      check("rst_framing", framing_error, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_strobe", shift_strobe, 1'b0);
      idle(4, 0);

      // Good frame 8'hA5
      stb_q.delete();
      send_frame(8'hA5, 1'b1, 0, 1'b0);
      idle(3, 0);
      check("a5_strobe_count", stb_q.size(), 9);
      for (int i = 1; i < stb_q.size(); i++)
         check("a5_strobe_gap", stb_q[i] - stb_q[i-1], N);
      check("a5_rx_data", rx_data, 8'hA5);
      check("a5_data_ready", data_ready, 1'b1);
      check("a5_framing", framing_error, 1'b0);

      // 3-cycle glitch on the idle line
      stb_q.delete();
      repeat (3) step(1'b0, 1'b0);
      idle(15, 0);
      check("glitch_no_strobe", stb_q.size(), 0);
      check("glitch_busy", busy, 1'b0);
      check("glitch_rx_data", rx_data, 8'hA5);
      check("glitch_ready", data_ready, 1'b1);

      // Frame 8'h3C with a bad stop bit, then a good frame clears the flag
      send_frame(8'h3C, 1'b0, 0, 1'b0);
      idle(3, 0);
      check("fe_set", framing_error, 1'b1);
      check("fe_rx_kept", rx_data, 8'hA5);
      check("fe_ready_kept", data_ready, 1'b1);
      send_frame(8'h5A, 1'b1, 0, 1'b1);
      idle(2, 0);
      check("fe_after_good", framing_error, 1'b0);
      step(1'b1, 1'b1);
      check("read_clears_ready", data_ready, 1'b0);

      // Two frames with no read in between
      send_frame(8'h11, 1'b1, 0, 1'b0);
      send_frame(8'h22, 1'b1, 0, 1'b0);
      idle(2, 0);
      check("ovr_rx_data", rx_data, 8'h22);
      check("ovr_set", overrun_error, 1'b1);
      step(1'b1, 1'b1);
      check("ovr_read_ready", data_ready, 1'b0);
      check("ovr_read_ovr", overrun_error, 1'b0);

      // Read coincident with LOAD while an overrun is pending
      send_frame(8'h33, 1'b1, 0, 1'b0);
      send_frame(8'h44, 1'b1, 0, 1'b0);
      check("pre_load_ovr", overrun_error, 1'b1);
      send_frame(8'h55, 1'b1, 2, 1'b0);
      idle(2, 0);
      check("load_read_ready", data_ready, 1'b1);
      check("load_read_ovr", overrun_error, 1'b0);
      check("load_read_rx", rx_data, 8'h55);

      // Reset in the middle of a frame
      for (int i = 0; i < 3 * N; i++) step(1'b0, 1'b0);
      check("midframe_busy", busy, 1'b1);
      #2 n_rst = 1'b0;
      #1;
      check("mid_rst_rx_data", rx_data, 8'hFF);
      check("mid_rst_ready", data_ready, 1'b0);
      check("mid_rst_ovr", overrun_error, 1'b0);
      check("mid_rst_fe", framing_error, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_strobe", shift_strobe, 1'b0);
      serial_in = 1'b1;
      repeat (2) @(posedge clk);
      #3 n_rst = 1'b1;
      @(posedge clk);
      #1;
      idle(20, 0);
      check("post_rst_busy", busy, 1'b0);

      // Random frames, glitches, gaps and reads
      for (int f = 0; f < 40; f++) begin
         logic stop;
         if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(1, 3)) step(1'b0, 1'b0);
            idle(8, 1);
         end
         stop = ($urandom_range(0, 7) != 0);
         send_frame(8'($urandom_range(0, 255)), stop, 1, 1'b0);
         idle(stop ? $urandom_range(0, 12) : $urandom_range(2, 12), 1);
      end
      idle(10, 0);
      check("frames_all_consumed", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
